// File: rtl/conv_icb_pkg.sv
// ============================================================================
// Package  : conv_icb_pkg
// Desc     : Register map and sequencing types shared by the conv accelerator
//            ICB slave and its initiator, so both sides agree on addresses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package conv_icb_pkg;

    // Register offsets relative to the slave base address
    localparam logic [31:0] IMAGE1_OFS  = 32'h0000_0000;
    localparam logic [31:0] IMAGE2_OFS  = 32'h0000_0004;
    localparam logic [31:0] IMAGE3_OFS  = 32'h0000_0008;
    localparam logic [31:0] IMAGE4_OFS  = 32'h0000_000C;
    localparam logic [31:0] FILTER1_OFS = 32'h0000_0010;
    localparam logic [31:0] FILTER2_OFS = 32'h0000_0040;
    localparam logic [31:0] FILTER3_OFS = 32'h0000_0080;
    localparam logic [31:0] CONTROL_OFS = 32'h0000_00C0;
    localparam logic [31:0] SUM_OFS     = 32'h0000_0100;

    // One job = 8 register writes followed by a single SUM read
    localparam int NUM_STEPS = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Register offset targeted by each step of the job sequence
    function automatic logic [31:0] step_offset(input logic [3:0] idx);
        logic [31:0] ofs;
        case (idx)
            4'd0:    ofs = IMAGE1_OFS;
            4'd1:    ofs = IMAGE2_OFS;
            4'd2:    ofs = IMAGE3_OFS;
            4'd3:    ofs = IMAGE4_OFS;
            4'd4:    ofs = FILTER1_OFS;
            4'd5:    ofs = FILTER2_OFS;
            4'd6:    ofs = FILTER3_OFS;
            4'd7:    ofs = CONTROL_OFS;
            4'd8:    ofs = SUM_OFS;
            default: ofs = 32'h0000_0000;
        endcase
        return ofs;
    endfunction

endpackage

`default_nettype wire

// File: rtl/icb_conv_master.sv
// ============================================================================
// Module   : icb_conv_master
// Desc     : ICB initiator for the conv accelerator. Takes one job (image,
//            filter, control words), writes them to the slave registers one
//            transaction at a time, reads SUM back and returns it with an
//            accumulated error flag.
// Config   : ICB_MASTER_TIMEOUT_EN - when defined, a CMD or RSP wait lasting
//            TIMEOUT_CYC cycles abandons the job with result_err=1, sum=0.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module icb_conv_master
    import conv_icb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1004_2000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    // job input
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [127:0] job_image,
    input  logic [95:0]  job_filter,
    input  logic [31:0]  job_ctrl,
    // result output
    output logic         result_valid,
    input  logic         result_ready,
    output logic [31:0]  result_sum,
    output logic         result_err,
    // ICB command channel
    output logic         icb_cmd_valid,
    input  logic         icb_cmd_ready,
    output logic         icb_cmd_read,
    output logic [31:0]  icb_cmd_addr,
    output logic [31:0]  icb_cmd_wdata,
    output logic [3:0]   icb_cmd_wmask,
    // ICB response channel
    input  logic         icb_rsp_valid,
    output logic         icb_rsp_ready,
    input  logic [31:0]  icb_rsp_rdata,
    input  logic         icb_rsp_err
);

    state_t        r_state;
    logic [3:0]    r_idx;
    logic          r_err_acc;
    logic [127:0]  r_image;
    logic [95:0]   r_filter;
    logic [31:0]   r_ctrl;
    logic [31:0]   r_sum;

    logic          w_last;
    logic          w_read;
    logic [31:0]   w_offset;
    logic [31:0]   w_wdata;
    logic          w_timeout;

    assign w_last = (r_idx == 4'(NUM_STEPS - 1));

    // Decode the current step index into command fields
    always_comb begin
        w_read   = w_last;
        w_offset = step_offset(r_idx);
        w_wdata  = 32'h0000_0000;
        case (r_idx)
            4'd0:    w_wdata = r_image[31:0];
            4'd1:    w_wdata = r_image[63:32];
            4'd2:    w_wdata = r_image[95:64];
            4'd3:    w_wdata = r_image[127:96];
            4'd4:    w_wdata = r_filter[31:0];
            4'd5:    w_wdata = r_filter[63:32];
            4'd6:    w_wdata = r_filter[95:64];
            4'd7:    w_wdata = r_ctrl;
            default: w_wdata = 32'h0000_0000;
        endcase
    end

    // Handshake and command outputs follow the registered state; fields are
    // zeroed outside CMD so the bus is quiet when nothing is offered.
    assign job_ready     = (r_state == IDLE);
    assign icb_cmd_valid = (r_state == CMD);
    assign icb_rsp_ready = (r_state == RSP);
    assign result_valid  = (r_state == DONE);
    assign result_err    = (r_state == DONE) && r_err_acc;
    assign result_sum    = r_sum;
    assign icb_cmd_read  = icb_cmd_valid && w_read;
    assign icb_cmd_addr  = icb_cmd_valid ? (BASE_ADDR + w_offset) : 32'h0000_0000;
    assign icb_cmd_wdata = (icb_cmd_valid && !w_read) ? w_wdata : 32'h0000_0000;
    assign icb_cmd_wmask = (icb_cmd_valid && !w_read) ? 4'hF : 4'h0;

`ifdef ICB_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_waiting;

    // A wait is any CMD/RSP cycle without the peer's handshake
    assign w_waiting = ((r_state == CMD) && !icb_cmd_ready) ||
                       ((r_state == RSP) && !icb_rsp_valid);
    assign w_timeout = w_waiting && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Count consecutive wait cycles; any handshake (state exit) clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_waiting && !w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

    // Job sequencer: latch job, issue one transaction per step, collect SUM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= 4'd0;
            r_err_acc <= 1'b0;
            r_image   <= '0;
            r_filter  <= '0;
            r_ctrl    <= '0;
            r_sum     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (job_valid) begin
                        r_image   <= job_image;
                        r_filter  <= job_filter;
                        r_ctrl    <= job_ctrl;
                        r_idx     <= 4'd0;
                        r_err_acc <= 1'b0;
                        r_state   <= CMD;
                    end
                end
                CMD: begin
                    if (w_timeout) begin
                        r_err_acc <= 1'b1;
                        r_sum     <= '0;
                        r_state   <= DONE;
                    end else if (icb_cmd_ready) begin
                        r_state <= RSP;
                    end
                end
                RSP: begin
                    if (w_timeout) begin
                        r_err_acc <= 1'b1;
                        r_sum     <= '0;
                        r_state   <= DONE;
                    end else if (icb_rsp_valid) begin
                        r_err_acc <= r_err_acc | icb_rsp_err;
                        if (w_last) begin
                            r_sum   <= icb_rsp_rdata;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= CMD;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icb_conv_master.sv
// ============================================================================
// Module   : tb_icb_conv_master
// Desc     : Self-checking bench for icb_conv_master with a reactive ICB slave
//            model and a table-driven reference of the expected job sequence.
// Config   : ICB_MASTER_TIMEOUT_EN - enables the slave-never-ready scenario.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_icb_conv_master;

    localparam logic [31:0] BASE = 32'h1004_2000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         job_valid, job_ready;
    logic [127:0] job_image;
    logic [95:0]  job_filter;
    logic [31:0]  job_ctrl;
    logic         result_valid, result_ready, result_err;
    logic [31:0]  result_sum;
    logic         icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0]  icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]   icb_cmd_wmask;
    logic         icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0]  icb_rsp_rdata;

    always #5 clk = ~clk;

    icb_conv_master #(.BASE_ADDR(BASE), .TIMEOUT_CYC(16)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_image     (job_image),
        .job_filter    (job_filter),
        .job_ctrl      (job_ctrl),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_sum    (result_sum),
        .result_err    (result_err),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model of one job ----------------
    logic [31:0] ref_off [9] = '{32'h000, 32'h004, 32'h008, 32'h00C,
                                 32'h010, 32'h040, 32'h080, 32'h0C0, 32'h100};

    function automatic logic [31:0] ref_wdata(input logic [127:0] img, input logic [95:0] flt,
                                              input logic [31:0] ctl, input int k);
        if (k < 4)  return img[32*k +: 32];
        if (k < 7)  return flt[32*(k-4) +: 32];
        if (k == 7) return ctl;
        return 32'h0;
    endfunction

    // ---------------- slave model (config written by main only) ----------------
    int          dly_mode    = 0;   // 0: ready after 1 cycle, 1: after 5, 2: random 1..4
    int          err_idx     = -1;  // job-relative step answering with rsp_err
    logic [31:0] sum_val     = 32'h0;
    logic        never_ready = 1'b0;
    logic        spur        = 1'b0; // unsolicited rsp_valid
    int          job_base    = 0;

    // slave-owned state
    int          txn_total   = 0;
    int          stab_viol   = 0;
    int          outst_viol  = 0;
    logic        log_read [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_mask [$];

    initial begin
        logic        s_cv, s_cr, s_rv, s_rr, s_rd, p_rd, prev_wait, rsp_out, rsp_pending;
        logic [31:0] s_addr, s_wd, p_addr, p_wd;
        logic [3:0]  s_mk, p_mk;
        int          slv_cnt, slv_dly;
        prev_wait = 0; rsp_out = 0; rsp_pending = 0; slv_cnt = 0; slv_dly = 1;
        p_rd = 0; p_addr = 0; p_wd = 0; p_mk = 0;
        icb_cmd_ready = 0; icb_rsp_valid = 0; icb_rsp_rdata = 0; icb_rsp_err = 0;
        forever begin
            @(negedge clk);
            s_cv = icb_cmd_valid; s_cr = icb_cmd_ready;
            s_rv = icb_rsp_valid; s_rr = icb_rsp_ready;
            s_rd = icb_cmd_read; s_addr = icb_cmd_addr; s_wd = icb_cmd_wdata; s_mk = icb_cmd_wmask;
            if (prev_wait && s_cv && ({s_rd, s_addr, s_wd, s_mk} != {p_rd, p_addr, p_wd, p_mk}))
                stab_viol++;
            prev_wait = s_cv && !s_cr;
            p_rd = s_rd; p_addr = s_addr; p_wd = s_wd; p_mk = s_mk;
            if (s_cv && rsp_pending) outst_viol++;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                icb_cmd_ready = 0; rsp_out = 0; rsp_pending = 0; slv_cnt = 0; prev_wait = 0;
            end else begin
                if (s_rv && s_rr) begin
                    rsp_out = 0; rsp_pending = 0;
                end
                if (s_cv && s_cr) begin
                    log_read.push_back(s_rd); log_addr.push_back(s_addr);
                    log_wdata.push_back(s_wd); log_mask.push_back(s_mk);
                    icb_cmd_ready = 0; slv_cnt = 0;
                    rsp_out = 1; rsp_pending = 1;
                    icb_rsp_rdata = s_rd ? sum_val : $urandom;
                    icb_rsp_err   = ((txn_total - job_base) == err_idx);
                    txn_total++;
                end else if (s_cv && !icb_cmd_ready && !never_ready) begin
                    if (slv_cnt == 0)
                        slv_dly = (dly_mode == 1) ? 5 : (dly_mode == 2) ? int'($urandom_range(1, 4)) : 1;
                    slv_cnt++;
                    if (slv_cnt >= slv_dly) icb_cmd_ready = 1;
                end
            end
            icb_rsp_valid = rsp_out || spur;
        end
    end

    // ---------------- job driver ----------------
    task automatic offer_job(input logic [127:0] img, input logic [95:0] flt, input logic [31:0] ctl);
        int n;
        job_image = img; job_filter = flt; job_ctrl = ctl; job_valid = 1;
        n = 0;
        @(negedge clk);
        while (!job_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("job_accept_wait", job_ready, 1);
        @(posedge clk);
        #2;
        job_valid  = 0;
        job_image  = {$urandom, $urandom, $urandom, $urandom};
        job_filter = {$urandom, $urandom, $urandom};
        job_ctrl   = $urandom;
    endtask

    task automatic run_job(input logic [127:0] img, input logic [95:0] flt, input logic [31:0] ctl,
                           input int dm, input int ei, input logic [31:0] sv,
                           input int exp_lat, input int hold);
        int base, sv0, ov0, cyc, hviol;
        logic [31:0] hsum;
        logic        herr;
        dly_mode = dm; err_idx = ei; sum_val = sv;
        base = log_addr.size(); job_base = txn_total;
        sv0 = stab_viol; ov0 = outst_viol;
        offer_job(img, flt, ctl);
        cyc = 0;
        while (!result_valid && cyc < 3000) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check_val("result_valid_wait", result_valid, 1);
        if (exp_lat > 0) check_val("latency", cyc, exp_lat);
        check_val("result_sum", result_sum, sv);
        check_val("result_err", result_err, (ei >= 0 && ei < 9));
        check_val("job_ready_busy", job_ready, 0);
        check_val("txn_count", log_addr.size() - base, 9);
        for (int k = 0; k < 9; k++) begin
            if (base + k < log_addr.size()) begin
                check_val("txn_addr",  log_addr[base+k],  BASE + ref_off[k]);
                check_val("txn_read",  log_read[base+k],  (k == 8));
                check_val("txn_wdata", log_wdata[base+k], ref_wdata(img, flt, ctl, k));
                check_val("txn_wmask", log_mask[base+k],  (k == 8) ? 4'h0 : 4'hF);
            end
        end
        check_val("cmd_stable", stab_viol - sv0, 0);
        check_val("one_outstanding", outst_viol - ov0, 0);
        if (hold > 0) begin
            hsum = result_sum; herr = result_err; hviol = 0;
            job_image = {$urandom, $urandom, $urandom, $urandom};
            job_valid = 1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #2;
                if (!result_valid || result_sum !== hsum || result_err !== herr || job_ready) hviol++;
            end
            check_val("done_hold", hviol, 0);
        end
        result_ready = 1;
        @(posedge clk);
        #2;
        result_ready = 0;
        job_valid    = 0;
        check_val("idle_after_release", {job_ready, result_valid}, 2'b10);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst_n = 0; job_valid = 0; job_image = 0; job_filter = 0; job_ctrl = 0; result_ready = 0;
        spur = 1;
        repeat (3) @(posedge clk);
        #2;
        check_val("reset_outputs",
                  {job_ready, icb_cmd_valid, icb_rsp_ready, result_valid, result_err, icb_cmd_wmask},
                  {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        check_val("reset_sum", result_sum, 0);
        rst_n = 1;
        @(posedge clk);
        #2;
        check_val("idle_ignores_rsp", {icb_rsp_ready, job_ready, icb_cmd_valid}, 3'b010);
        spur = 0;
        @(posedge clk);
        #2;

        // T1: nominal job, 1-cycle slave, fixed latency
        run_job({32'd4, 32'd3, 32'd2, 32'd1}, {32'd7, 32'd6, 32'd5}, 32'd1, 0, -1, 32'h0000_00AB, 27, 0);
        // T2: slow slave ready
        run_job({32'd4, 32'd3, 32'd2, 32'd1}, {32'd7, 32'd6, 32'd5}, 32'd1, 1, -1, 32'h0000_00AB, 0, 0);
        // T3: error response on step 4 only
        run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, $urandom,
                0, 4, $urandom, 27, 0);
        // T4: consumer stalls the result
        run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, $urandom,
                0, -1, $urandom, 27, 10);
        // randomized jobs
        for (int j = 0; j < 8; j++) begin
            run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, $urandom,
                    ($urandom_range(0, 1) == 0) ? 0 : 2,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1,
                    $urandom, 0, 0);
        end

        // T5: reset while waiting for the response of step 5
        dly_mode = 0; err_idx = -1; job_base = txn_total;
        offer_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, $urandom);
        n = 0;
        while (!(((txn_total - job_base) == 6) && icb_rsp_ready) && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_val("t5_reach_rsp5", icb_rsp_ready, 1);
        rst_n = 0;
        @(posedge clk);
        #2;
        check_val("t5_reset_midjob", {icb_cmd_valid, icb_rsp_ready, job_ready, result_valid}, 4'b0010);
        rst_n = 1;
        @(posedge clk);
        #2;
        run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, $urandom,
                0, -1, $urandom, 27, 0);

`ifdef ICB_MASTER_TIMEOUT_EN
        // T6: slave never accepts the command
        never_ready = 1;
        offer_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, $urandom);
        n = 0;
        while (!result_valid && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_val("t6_timeout_latency", n, 16);
        check_val("t6_timeout_result", {result_valid, result_err, icb_cmd_valid}, 3'b110);
        check_val("t6_timeout_sum", result_sum, 0);
        result_ready = 1;
        @(posedge clk);
        #2;
        result_ready = 0;
        never_ready  = 0;
        check_val("t6_back_idle", job_ready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
